// File: rtl/audio_sequencer.sv
// Sample-ROM address sequencer: steps Add once per DIV data_over strobes.
// Optional pause support is enabled by defining AUDIO_SEQ_PAUSE_EN.
module audio_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DIV    = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              INIT,
  input  logic              Loop,
  input  logic [ADDR_W-1:0] Track_Start,
  input  logic [ADDR_W-1:0] Track_Len,
  input  logic              Stop,
  input  logic              data_over,
`ifdef AUDIO_SEQ_PAUSE_EN
  input  logic              Pause,
`endif
  output logic              INIT_FINISH,
  output logic [ADDR_W-1:0] Add,
  output logic              Done,
  output logic              Wrap
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

`ifdef AUDIO_SEQ_PAUSE_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              loop_q, loop_d;
  logic              fin_q, fin_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;
  logic              last;

  assign last = (idx_q == len_q - A_ONE);

  // Next-state: Stop beats INIT beats Pause beats data_over.
  always_comb begin
    state_d = state_q;
    add_d   = add_q;
    idx_d   = idx_q;
    start_d = start_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    priority case (1'b1)
      Stop: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      (INIT && (Track_Len != '0)): begin
        state_d = S_RUN;
        add_d   = Track_Start;
        idx_d   = '0;
        cnt_d   = '0;
        start_d = Track_Start;
        len_d   = Track_Len;
        loop_d  = Loop;
      end
`ifdef AUDIO_SEQ_PAUSE_EN
      (state_q == S_RUN && Pause): begin
        state_d = S_PAUSE;
      end
      (state_q == S_PAUSE): begin
        if (!Pause) state_d = S_RUN;
      end
`endif
      (state_q == S_RUN && data_over): begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (!last) begin
            idx_d = idx_q + A_ONE;
            add_d = add_q + A_ONE;
          end else if (loop_q) begin
            idx_d  = '0;
            add_d  = start_q;
            wrap_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: ;
    endcase
    fin_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      add_q   <= '0;
      idx_q   <= '0;
      start_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      loop_q  <= 1'b0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      add_q   <= add_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      loop_q  <= loop_d;
      fin_q   <= fin_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign INIT_FINISH = fin_q;
  assign Add         = add_q;
  assign Done        = done_q;
  assign Wrap        = wrap_q;

endmodule

// File: tb/tb_audio_sequencer.sv
// Bench for audio_sequencer: DIV=10 and DIV=1 instances share stimulus
// and are checked every cycle against a track-position model.
module tb_audio_sequencer;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset, INIT, Loop, Stop, data_over, Pause;
  logic [15:0] Track_Start, Track_Len;
  logic        fin0, fin1, done0, done1, wrap0, wrap1;
  logic [15:0] add0, add1;

`ifdef AUDIO_SEQ_PAUSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  audio_sequencer #(.ADDR_W(16), .DIV(10)) u_d10 (
    .Clk(Clk), .Reset(Reset), .INIT(INIT), .Loop(Loop),
    .Track_Start(Track_Start), .Track_Len(Track_Len),
    .Stop(Stop), .data_over(data_over),
`ifdef AUDIO_SEQ_PAUSE_EN
    .Pause(Pause),
`endif
    .INIT_FINISH(fin0), .Add(add0), .Done(done0), .Wrap(wrap0)
  );

  audio_sequencer #(.ADDR_W(16), .DIV(1)) u_d1 (
    .Clk(Clk), .Reset(Reset), .INIT(INIT), .Loop(Loop),
    .Track_Start(Track_Start), .Track_Len(Track_Len),
    .Stop(Stop), .data_over(data_over),
`ifdef AUDIO_SEQ_PAUSE_EN
    .Pause(Pause),
`endif
    .INIT_FINISH(fin1), .Add(add1), .Done(done1), .Wrap(wrap1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: a track is a position within [0,len); strobes accumulate
  // toward the divider and each full group moves the position on.
  int m_play[2], m_pause[2], m_add[2], m_strobes[2], m_pos[2];
  int m_start[2], m_len[2], m_loop[2], m_done[2], m_wrap[2];

  function automatic int divof(input int k);
    return (k == 0) ? 10 : 1;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!Reset) begin
        m_play[k] = 0; m_pause[k] = 0; m_add[k] = 0;
        m_strobes[k] = 0; m_pos[k] = 0; m_start[k] = 0;
        m_len[k] = 0; m_loop[k] = 0; m_done[k] = 0; m_wrap[k] = 0;
      end else begin
        m_done[k] = 0;
        m_wrap[k] = 0;
        if (Stop) begin
          m_play[k] = 0;
          m_pause[k] = 0;
          m_strobes[k] = 0;
        end else if (INIT && Track_Len != 0) begin
          m_play[k] = 1; m_pause[k] = 0;
          m_start[k] = Track_Start; m_len[k] = Track_Len;
          m_loop[k] = Loop; m_pos[k] = 0; m_strobes[k] = 0;
          m_add[k] = Track_Start;
        end else if (PEN && m_play[k] != 0 && m_pause[k] == 0 && Pause) begin
          m_pause[k] = 1;
        end else if (m_pause[k] != 0) begin
          if (!Pause) m_pause[k] = 0;
        end else if (m_play[k] != 0 && data_over) begin
          m_strobes[k] = m_strobes[k] + 1;
          if (m_strobes[k] == divof(k)) begin
            m_strobes[k] = 0;
            if (m_pos[k] + 1 < m_len[k]) begin
              m_pos[k] = m_pos[k] + 1;
              m_add[k] = (m_start[k] + m_pos[k]) % 65536;
            end else if (m_loop[k] != 0) begin
              m_pos[k] = 0;
              m_add[k] = m_start[k];
              m_wrap[k] = 1;
            end else begin
              m_play[k] = 0;
              m_done[k] = 1;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("d10.Add", add0, m_add[0]);
    chk("d10.INIT_FINISH", fin0, m_play[0]);
    chk("d10.Done", done0, m_done[0]);
    chk("d10.Wrap", wrap0, m_wrap[0]);
    chk("d1.Add", add1, m_add[1]);
    chk("d1.INIT_FINISH", fin1, m_play[1]);
    chk("d1.Done", done1, m_done[1]);
    chk("d1.Wrap", wrap1, m_wrap[1]);
  endtask

  task automatic cyc(input logic i, input logic [15:0] s,
                     input logic [15:0] l, input logic lp,
                     input logic st, input logic d);
    INIT = i; Track_Start = s; Track_Len = l;
    Loop = lp; Stop = st; data_over = d;
    @(negedge Clk);
    cmp_all();
  endtask

  int wraps;
  int maxadd;

  initial begin
    Reset = 1'b0; INIT = 0; Loop = 0; Stop = 0;
    data_over = 0; Pause = 0; Track_Start = 0; Track_Len = 0;
    @(negedge Clk);
    @(negedge Clk);
    chk("reset.Add", add0, 0);
    chk("reset.INIT_FINISH", fin0, 0);
    chk("reset.Done", done0, 0);
    chk("reset.Wrap", wrap0, 0);
    Reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 1);

    // Looping window from 0, scaled-down length
    cyc(1, 16'd0, 16'd50, 1, 0, 0);
    wraps = 0; maxadd = 0;
    for (int i = 0; i < 500; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      if (wrap0) wraps++;
      if (add0 > maxadd) maxadd = add0;
    end
    chk("loop.wraps", wraps, 1);
    chk("loop.maxadd", maxadd, 49);
    chk("loop.Add", add0, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // One-shot, 3 samples from 100
    cyc(1, 16'd100, 16'd3, 0, 0, 0);
    chk("oneshot.start", add0, 100);
    for (int i = 1; i <= 30; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      if (i == 10) chk("oneshot.a101", add0, 101);
      if (i == 20) chk("oneshot.a102", add0, 102);
      if (i == 29) chk("oneshot.fin29", fin0, 1);
      if (i == 30) begin
        chk("oneshot.done", done0, 1);
        chk("oneshot.fin", fin0, 0);
        chk("oneshot.hold", add0, 102);
      end
    end
    cyc(0, 0, 0, 0, 1, 0);

    // DIV=1 window wrapping through zero
    cyc(1, 16'hFFFE, 16'd4, 1, 0, 0);
    chk("wrap0.s0", add1, 16'hFFFE);
    cyc(0, 0, 0, 0, 0, 1);
    chk("wrap0.s1", add1, 16'hFFFF);
    cyc(0, 0, 0, 0, 0, 1);
    chk("wrap0.s2", add1, 16'h0000);
    cyc(0, 0, 0, 0, 0, 1);
    chk("wrap0.s3", add1, 16'h0001);
    chk("wrap0.nowrap", wrap1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("wrap0.s4", add1, 16'hFFFE);
    chk("wrap0.wrap", wrap1, 1);
    cyc(0, 0, 0, 0, 1, 0);

    // Stop coinciding with the step strobe
    cyc(1, 16'd100, 16'd10, 0, 0, 0);
    for (int i = 0; i < 59; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("stop.pre", add0, 105);
    cyc(0, 0, 0, 0, 1, 1);
    chk("stop.add", add0, 105);
    chk("stop.fin", fin0, 0);
    chk("stop.done", done0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("stop.idle", add0, 105);

    // Zero-length retrigger ignored, real retrigger restarts count
    cyc(1, 16'd100, 16'd5, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 16'd500, 16'd0, 1, 0, 0);
    chk("len0.fin", fin0, 1);
    chk("len0.add", add0, 100);
    cyc(1, 16'd500, 16'd2, 1, 0, 0);
    chk("retrig.add", add0, 500);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("retrig.9", add0, 500);
    cyc(0, 0, 0, 0, 0, 1);
    chk("retrig.10", add0, 501);
    cyc(0, 0, 0, 0, 1, 0);

`ifdef AUDIO_SEQ_PAUSE_EN
    // Pause freezes the divider mid-count
    cyc(1, 16'd0, 16'd8, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
    Pause = 1;
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, (i != 0));
    chk("pause.add", add0, 0);
    chk("pause.fin", fin0, 1);
    Pause = 0;
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("pause.resume", add0, 1);
    cyc(0, 0, 0, 0, 1, 0);
`endif

    // Mid-playback reset
    cyc(1, 16'd1234, 16'd9, 1, 0, 0);
    for (int i = 0; i < 25; i++) cyc(0, 0, 0, 0, 0, 1);
    Reset = 1'b0;
    #1;
    chk("areset.add", add0, 0);
    chk("areset.fin", fin0, 0);
    @(negedge Clk);
    Reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 20000; n++) begin
      Reset = ($urandom_range(999) != 0);
      INIT = ($urandom_range(99) < 3);
      Track_Len = ($urandom_range(7) == 0) ? 16'd0
                                           : 16'($urandom_range(12, 1));
      Track_Start = ($urandom_range(3) == 0)
                      ? 16'(16'hFFF8 + $urandom_range(7))
                      : 16'($urandom);
      Loop = $urandom_range(1);
      Stop = ($urandom_range(199) == 0);
      data_over = ($urandom_range(9) < 7);
      if ($urandom_range(49) == 0) Pause = ~Pause;
      @(negedge Clk);
      cmp_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
